uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal 5..8.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: rx synchronizer depth, legal 2..3.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port prescale  input  16  clk cycles per bit period.
REQ-006 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 SHALL have port rx_data  output  DATA_BITS  last good byte received.
REQ-008 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-009 SHALL have port rx_busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port rx_error  output  1  one-cycle pulse on framing or parity error.

Function
REQ-011 SHALL pass rx through SYNC_STAGES flops; all decisions use the synchronized value.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE: on synchronized falling edge (previous 1, current 1->0), latch P = max(prescale, 4) and go to START.
REQ-014 Later prescale changes SHALL NOT affect the frame in progress.
REQ-015 START: after P>>1 cycles, sample; 0 -> DATA with bit counter 0; 1 -> false start, back to IDLE, no pulse.
REQ-016 DATA: sample every P cycles, LSB first, shift into a holding register; after DATA_BITS samples go to PARITY (macro defined) or STOP.
REQ-017 PARITY: sample after P cycles; record mismatch against the even parity of the data bits; go to STOP.
REQ-018 STOP: sample after P cycles.
REQ-019 STOP sample 1 with no parity mismatch: load rx_data, pulse rx_valid for exactly 1 cycle, go to IDLE.
REQ-020 STOP sample 0 or parity mismatch: pulse rx_error for 1 cycle, leave rx_data unchanged, go to IDLE.
REQ-021 rx_valid and rx_error SHALL never be high in the same cycle.
REQ-022 rx_valid or rx_error SHALL assert in the cycle after the stop sample.
REQ-023 After a framing error, IDLE SHALL NOT start a new frame until rx is seen high, so a held-low break yields exactly one error.
REQ-024 rx_busy SHALL be 1 in every state except IDLE; it deasserts together with the rx_valid/rx_error pulse.
REQ-025 The bit-period counter SHALL be 16 bits wide and reload, not free-run, so there is no wrap-around drift across a frame.
REQ-026 Back-to-back frames (next start bit right after stop mid-sample) SHALL be received without loss.

Reset
REQ-027 Asserting reset (low) SHALL immediately force IDLE, rx_data=0, rx_valid=0, rx_busy=0, rx_error=0, counters 0, and the synchronizer to all-1.
REQ-028 Reset mid-frame SHALL discard the partial frame with no pulse; after release, a frame is accepted only after a fresh falling edge.

Configuration
REQ-029 UART_RX_PARITY_EN defined: frame includes one even-parity bit after the data, checked per REQ-017.
REQ-030 UART_RX_PARITY_EN undefined: no PARITY state, no parity logic; stop bit follows the last data bit; ports are unchanged.

Structure
REQ-031 Shared package uart_pkg SHALL hold the state enum typedef, UART_MIN_PRESCALE=4 and UART_IDLE_LEVEL=1'b1, for reuse by uart_tx.
REQ-032 The synchronizer SHALL be a separate sub-module uart_sync (parameter STAGES, reset value 1); the rest stays in uart_receiver.

Verification
REQ-033 prescale=16, frame 0xA5 with good stop -> rx_data=0xA5, one rx_valid pulse about 2+8+9*16=154 cycles (±2) after the falling edge, rx_busy high throughout.
REQ-034 prescale=16, 4-cycle low glitch on idle line -> false start, no rx_valid, no rx_error, rx_busy drops after about 10 cycles.
REQ-035 prescale=16, 0x3C with stop bit 0, then line held low 40 bit times, then high, then 0x55 -> exactly one rx_error, rx_data stays at prior value, then rx_data=0x55 with rx_valid.
REQ-036 prescale=2 (clamped to 4), frames 0x00, 0xFF, 0x81 back-to-back -> three rx_valid pulses with matching data.
REQ-037 reset pulsed low during bit 4 of 0x5A, then 0xC3 sent -> no pulse for 0x5A, rx_data=0xC3.
REQ-038 With UART_RX_PARITY_EN: 0x07 with parity 0 (wrong) -> rx_error only; with parity 1 -> rx_valid and rx_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line constants
// and the prescale clamp used by both receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [15:0] UART_MIN_PRESCALE = 16'd4;
    localparam logic        UART_IDLE_LEVEL   = 1'b1;

    function automatic logic [15:0] uart_clamp(input logic [15:0] p);
        return (p < UART_MIN_PRESCALE) ? UART_MIN_PRESCALE : p;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous rx line.
// Resets to the idle line level so reset never fakes a start bit.
module uart_sync
    import uart_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff <= {STAGES{UART_IDLE_LEVEL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8N1-style frames, mid-bit sampling, latched prescale.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          prescale,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 rx_error
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_START  = ST_START;
    localparam logic [2:0] S_DATA   = ST_DATA;
    localparam logic [2:0] S_STOP   = ST_STOP;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = ST_PARITY;
`endif
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    logic                   rx_s;
    logic                   rx_prev;
    logic                   armed;
    logic [SYNC_STAGES-1:0] warm;
    logic [2:0]             state;
    logic [15:0]            p_lat;
    logic [15:0]            cnt;
    logic [15:0]            p_in;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   tick;
    logic                   fall;
    logic                   warm_ok;
    logic                   perr;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign p_in    = uart_clamp(prescale);
    assign tick    = (cnt == 16'd0);
    assign warm_ok = warm[SYNC_STAGES-1];
    assign fall    = armed & rx_prev & ~rx_s;
    assign rx_busy = (state != S_IDLE);

`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            rx_prev  <= UART_IDLE_LEVEL;
            warm     <= '0;
            armed    <= 1'b0;
            p_lat    <= '0;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr     <= 1'b0;
`endif
        end else begin
            rx_prev  <= rx_s;
            warm     <= {warm[SYNC_STAGES-2:0], 1'b1};
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        p_lat <= p_in;
                        cnt   <= (p_in >> 1) - 16'd1;
                        state <= S_START;
                    end else if (!armed) begin
                        // Re-arm only after two idle bit periods of real high line
                        if (!warm_ok || !rx_s) begin
                            cnt     <= p_in - 16'd1;
                            bit_cnt <= '0;
                        end else if (tick) begin
                            if (bit_cnt == 4'd1) armed <= 1'b1;
                            bit_cnt <= bit_cnt + 4'd1;
                            cnt     <= p_in - 16'd1;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                end
                S_START: begin
                    if (!tick) begin
                        cnt <= cnt - 16'd1;
                    end else if (rx_s) begin
                        state <= S_IDLE;
                    end else begin
                        cnt     <= p_lat - 16'd1;
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!tick) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        cnt   <= p_lat - 16'd1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (!tick) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        perr  <= rx_s ^ (^shreg);
                        cnt   <= p_lat - 16'd1;
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (!tick) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        state <= S_IDLE;
                        if (rx_s && !perr) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                            if (!rx_s) armed <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames queue their
// expected pulses; a negedge monitor pops and compares each pulse.
module tb_uart_receiver;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

`ifdef UART_RX_PARITY_EN
    localparam int LAT = 170;
`else
    localparam int LAT = 154;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] prescale;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_busy;
    logic        rx_error;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   fall_cyc = 0;
    int   last_pulse = 0;
    logic prev_v = 1'b0;
    exp_t exp_q[$];
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_receiver #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .prescale (prescale),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .rx_error (rx_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid || rx_error) begin
            exp_t e;
            last_pulse = cyc;
            check("valid_error_excl", {31'd0, rx_valid & rx_error}, 0);
            check("pulse_width", {31'd0, rx_valid & prev_v}, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, rx_valid, rx_error}, 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, rx_error}, {31'd0, e.err});
                check("pulse_data", {24'd0, rx_data}, {24'd0, e.data});
            end
        end
        prev_v = rx_valid;
    end

    task automatic bit_out(input logic b, input int p, input logic chk);
        rx = b;
        repeat (p / 2) @(negedge clk);
        if (chk) check("busy_in_frame", {31'd0, rx_busy}, 1);
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input int p, input logic chk);
        @(negedge clk);
        fall_cyc = cyc;
        bit_out(1'b0, p, chk);
        for (int i = 0; i < 8; i++) bit_out(d[i], p, chk);
`ifdef UART_RX_PARITY_EN
        bit_out((^d) ^ par_flip, p, chk);
`endif
        bit_out(stop_b, p, chk);
    endtask

    initial begin
        int g;
        int d;
        reset    = 1'b0;
        rx       = 1'b1;
        prescale = 16'd16;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, rx_data}, 0);
        check("rst_valid", {31'd0, rx_valid}, 0);
        check("rst_busy", {31'd0, rx_busy}, 0);
        check("rst_error", {31'd0, rx_error}, 0);
        reset = 1'b1;
        repeat (60) @(negedge clk);

        // 0xA5, good stop, busy and latency checked
        exp_q.push_back('{err: 1'b0, data: 8'hA5});
        send_frame(8'hA5, 1'b1, 16, 1'b1);
        repeat (5) @(negedge clk);
        d = last_pulse - fall_cyc;
        check("latency", {31'd0, (d >= LAT - 2) && (d <= LAT + 2)}, 1);
        check("busy_after", {31'd0, rx_busy}, 0);
        repeat (20) @(negedge clk);

        // 4-cycle glitch: false start
        rx = 1'b0;
        g = cyc;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy", {31'd0, rx_busy}, 1);
        repeat (8) @(negedge clk);
        check("glitch_idle", {31'd0, rx_busy}, 0);
        check("glitch_time", {31'd0, (cyc - g) < 20}, 1);
        repeat (40) @(negedge clk);

        // Framing error then 40-bit break, then 0x55
        exp_q.push_back('{err: 1'b1, data: 8'hA5});
        send_frame(8'h3C, 1'b0, 16, 1'b0);
        repeat (40 * 16) @(negedge clk);
        check("break_busy", {31'd0, rx_busy}, 0);
        check("break_data", {24'd0, rx_data}, 32'hA5);
        rx = 1'b1;
        repeat (80) @(negedge clk);
        exp_q.push_back('{err: 1'b0, data: 8'h55});
        fork
            send_frame(8'h55, 1'b1, 16, 1'b0);
            begin
                repeat (40) @(negedge clk);
                prescale = 16'd4;
            end
        join
        repeat (10) @(negedge clk);
        check("data_55", {24'd0, rx_data}, 32'h55);

        // prescale=2 clamps to 4, back-to-back frames
        prescale = 16'd2;
        repeat (40) @(negedge clk);
        exp_q.push_back('{err: 1'b0, data: 8'h00});
        exp_q.push_back('{err: 1'b0, data: 8'hFF});
        exp_q.push_back('{err: 1'b0, data: 8'h81});
        send_frame(8'h00, 1'b1, 4, 1'b0);
        send_frame(8'hFF, 1'b1, 4, 1'b0);
        send_frame(8'h81, 1'b1, 4, 1'b0);
        repeat (30) @(negedge clk);
        check("data_81", {24'd0, rx_data}, 32'h81);

        // Reset in bit 4 of 0x5A, then 0xC3
        prescale = 16'd16;
        repeat (40) @(negedge clk);
        fork
            send_frame(8'h5A, 1'b1, 16, 1'b0);
            begin
                repeat (89) @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                check("midrst_busy", {31'd0, rx_busy}, 0);
                check("midrst_data", {24'd0, rx_data}, 0);
                check("midrst_valid", {31'd0, rx_valid}, 0);
                repeat (2) @(negedge clk);
                reset = 1'b1;
            end
        join
        repeat (64) @(negedge clk);
        exp_q.push_back('{err: 1'b0, data: 8'hC3});
        send_frame(8'hC3, 1'b1, 16, 1'b0);
        repeat (20) @(negedge clk);
        check("data_C3", {24'd0, rx_data}, 32'hC3);

`ifdef UART_RX_PARITY_EN
        repeat (40) @(negedge clk);
        exp_q.push_back('{err: 1'b1, data: 8'hC3});
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, 16, 1'b0);
        par_flip = 1'b0;
        repeat (40) @(negedge clk);
        check("par_keep", {24'd0, rx_data}, 32'hC3);
        exp_q.push_back('{err: 1'b0, data: 8'h07});
        send_frame(8'h07, 1'b1, 16, 1'b0);
        repeat (20) @(negedge clk);
        check("par_data", {24'd0, rx_data}, 32'h07);
`endif

        repeat (100) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
